// File: rtl/prewish5k_input_responder_if.sv
// ---------------------------------------------------------------------------
// prewish5k_input_responder_if
// Purpose : strobe/data fetch handshake between the controller (master) and
//           the input responder (slave).
// Signals : STB_I  request strobe, master -> slave
//           DAT_I  request mask,   master -> slave
//           STB_O  acknowledge,    slave  -> master
//           DAT_O  response data,  slave  -> master
//
// Handshake: a request is accepted on any rising clock edge where STB_I=1
// and the responder is idle, and DAT_I is captured on that edge only.
// Exactly one cycle later STB_O is high for exactly one cycle with DAT_O
// valid. There is no back-pressure: STB_I seen while a request is in
// flight is dropped, not queued. DAT_O holds its value until the next ack.
// ---------------------------------------------------------------------------
interface prewish5k_input_responder_if;
    logic       STB_I;
    logic [7:0] DAT_I;
    logic       STB_O;
    logic [7:0] DAT_O;

    modport master (
        output STB_I,
        output DAT_I,
        input  STB_O,
        input  DAT_O
    );

    modport slave (
        input  STB_I,
        input  DAT_I,
        output STB_O,
        output DAT_O
    );
endinterface

// File: rtl/prewish5k_input_responder.sv
// ---------------------------------------------------------------------------
// prewish5k_input_responder
// Purpose : synchronizes and debounces 8 raw active-high inputs and answers
//           each fetch strobe with a one-cycle ack carrying the debounced
//           state ANDed with the requested mask.
// Ports   : CLK_I        system clock
//           RST_I        asynchronous active-low reset
//           bus          fetch handshake (slave side: STB_I/DAT_I in,
//                        STB_O/DAT_O out)
//           i_inputs     raw inputs, asynchronous to CLK_I
//           o_rise       one-cycle pulse per bit on a debounced 0->1 change
//           o_alive      MSB of a free-running counter
//           o_dbg_state  current handshake FSM state
// ---------------------------------------------------------------------------
module prewish5k_input_responder #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int ALIVE_BITS    = 23
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    prewish5k_input_responder_if.slave   bus,
    input  logic [7:0]                   i_inputs,
    output logic [7:0]                   o_rise,
    output logic                         o_alive,
    output logic [1:0]                   o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

    // ---------------- synchronizer + debounce ----------------
    logic [7:0]               sync1_q;
    logic [7:0]               sync2_q;
    logic [7:0]               stable_q;
    logic [7:0]               stable_d;
    logic [7:0]               rise_q;
    logic [7:0]               rise_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [8];
    logic [DEBOUNCE_BITS-1:0] cnt_d [8];

    // Each bit counts consecutive cycles of disagreement with its accepted
    // value; any agreement clears the count, so short glitches vanish.
    // The count is cleared at all-ones, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        cnt_d    = cnt_q;
        for (int n = 0; n < 8; n++) begin
            if (sync2_q[n] == stable_q[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] != CNT_MAX) begin
                cnt_d[n] = cnt_q[n] + DEBOUNCE_BITS'(1);
            end else begin
                stable_d[n] = sync2_q[n];
                cnt_d[n]    = '0;
                rise_d[n]   = sync2_q[n];
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            for (int n = 0; n < 8; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sync1_q  <= i_inputs;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_rise = rise_q;

    // ---------------- handshake FSM ----------------
    state_t     state_q;
    state_t     state_d;
    logic       mask_load;
    logic       ack_load;
    logic [7:0] mask_q;
    logic [7:0] dat_q;
    logic       stb_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_load = 1'b0;
        ack_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.STB_I) begin
                    mask_load = 1'b1;
                    state_d   = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                ack_load = 1'b1;
                state_d  = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The ack samples stable_d rather than stable_q so that a debounce
    // update landing on the same edge is already reflected in DAT_O.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            mask_q <= '0;
            dat_q  <= '0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= ack_load;
            if (mask_load) begin
                mask_q <= bus.DAT_I;
            end
            if (ack_load) begin
                dat_q <= stable_d & mask_q;
            end
        end
    end

    assign bus.STB_O   = stb_q;
    assign bus.DAT_O   = dat_q;
    assign o_dbg_state = state_q;

    // ---------------- alive counter ----------------
    logic [ALIVE_BITS-1:0] alive_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_q + ALIVE_BITS'(1);
        end
    end

    assign o_alive = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_input_responder.sv
module tb_prewish5k_input_responder;

    localparam int DB  = 3;
    localparam int AB  = 4;
    localparam int WIN = 1 << DB;   // consecutive disagreeing samples needed to accept a change

    // ---------------- clock / reset ----------------
    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic [7:0] i_inputs = 8'h00;
    logic [7:0] o_rise;
    logic       o_alive;
    logic [1:0] o_dbg_state;

    always #5 CLK_I = ~CLK_I;

    prewish5k_input_responder_if bus ();

    prewish5k_input_responder #(
        .DEBOUNCE_BITS (DB),
        .ALIVE_BITS    (AB)
    ) u_dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .bus         (bus),
        .i_inputs    (i_inputs),
        .o_rise      (o_rise),
        .o_alive     (o_alive),
        .o_dbg_state (o_dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // Inputs pass a 2-edge delay line; a bit's accepted value flips on the
    // edge where the last WIN delayed samples all disagree with it.
    logic [7:0]       m_d1, m_d2, m_stable, m_rise;
    logic [8*WIN-1:0] m_win;
    int unsigned      m_edges;

    function automatic logic [7:0] win_flips(input logic [8*WIN-1:0] w, input logic [7:0] st);
        logic [7:0] f;
        for (int n = 0; n < 8; n++) begin
            f[n] = 1'b1;
            for (int j = 0; j < WIN; j++) begin
                if (w[j*8+n] == st[n]) f[n] = 1'b0;
            end
        end
        return f;
    endfunction

    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            m_d1     <= '0;
            m_d2     <= '0;
            m_stable <= '0;
            m_rise   <= '0;
            m_win    <= '0;
            m_edges  <= 0;
        end else begin
            m_win    <= {m_win[8*WIN-9:0], m_d2};
            m_stable <= m_stable ^ win_flips({m_win[8*WIN-9:0], m_d2}, m_stable);
            m_rise   <= win_flips({m_win[8*WIN-9:0], m_d2}, m_stable) & ~m_stable;
            m_d2     <= m_d1;
            m_d1     <= i_inputs;
            m_edges  <= m_edges + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] rise_obs[$];
    logic [7:0] rise_exp[$];
    logic       stb_obs[$];

    // ---------------- driver tasks ----------------
    // One fetch from IDLE; returns the STB_O value seen after the accepting
    // edge, after the next edge and after the one following it.
    task automatic fetch(input logic [7:0] mask, input logic [7:0] dat_after,
                         output logic [2:0] stb_seen, output logic [7:0] dat_seen);
        @(negedge CLK_I);
        bus.STB_I = 1'b1;
        bus.DAT_I = mask;
        @(negedge CLK_I);
        bus.STB_I   = 1'b0;
        bus.DAT_I   = dat_after;
        stb_seen[0] = bus.STB_O;
        @(negedge CLK_I);
        stb_seen[1] = bus.STB_O;
        dat_seen    = bus.DAT_O;
        exp_q.push_back(m_stable & mask);
        @(negedge CLK_I);
        stb_seen[2] = bus.STB_O;
    endtask

    task automatic watch(input int n);
        rise_obs.delete();
        rise_exp.delete();
        stb_obs.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_I);
            rise_obs.push_back(o_rise);
            rise_exp.push_back(m_rise);
            stb_obs.push_back(bus.STB_O);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge CLK_I);
        total++;
        if ({bus.STB_O, bus.DAT_O, o_rise, o_alive} !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs got stb=%b dat=%h rise=%h alive=%b want all 0",
                     bus.STB_O, bus.DAT_O, o_rise, o_alive);
        end
        RST_I = 1'b1;
    endtask

    task automatic test_first_fetch();
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        fetch(8'hFF, 8'h00, s, d);
        e = exp_q.pop_front();
        total++;
        if (s !== 3'b010) begin
            bad++;
            $display("FAIL first_fetch_latency got %b want 010", s);
        end
        total++;
        if (d !== 8'h00 || d !== e) begin
            bad++;
            $display("FAIL first_fetch_data got %h want 00 (model %h)", d, e);
        end
    endtask

    task automatic test_rise();
        int pulses;
        int at;
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge CLK_I);
        i_inputs = 8'h01;
        watch(20);
        pulses = 0;
        at     = -1;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (rise_obs[i] !== rise_exp[i]) begin
                bad++;
                $display("FAIL rise_track[%0d] got %h want %h", i, rise_obs[i], rise_exp[i]);
            end
            if (rise_obs[i] !== 8'h00) begin
                pulses++;
                at = i;
            end
        end
        // first sampling edge is index 0; accepted 2+7 edges later
        total++;
        if (pulses !== 1 || at !== 9 || rise_obs[9] !== 8'h01) begin
            bad++;
            $display("FAIL rise_pulse got pulses=%0d at=%0d want pulses=1 at=9 value 01", pulses, at);
        end
        fetch(8'hFF, 8'h00, s, d);
        e = exp_q.pop_front();
        total++;
        if (s !== 3'b010 || d !== 8'h01 || d !== e) begin
            bad++;
            $display("FAIL rise_fetch got stb=%b dat=%h want 010 01 (model %h)", s, d, e);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seen;
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge CLK_I);
        i_inputs = 8'h09;
        watch(5);
        seen = 8'h00;
        for (int i = 0; i < 5; i++) seen |= rise_obs[i];
        i_inputs = 8'h01;
        watch(15);
        for (int i = 0; i < 15; i++) begin
            seen |= rise_obs[i];
            total++;
            if (rise_obs[i] !== rise_exp[i]) begin
                bad++;
                $display("FAIL glitch_track[%0d] got %h want %h", i, rise_obs[i], rise_exp[i]);
            end
        end
        total++;
        if (seen !== 8'h00) begin
            bad++;
            $display("FAIL glitch_no_rise got %h want 00", seen);
        end
        fetch(8'hFF, 8'h00, s, d);
        e = exp_q.pop_front();
        total++;
        if (d !== 8'h01 || d !== e) begin
            bad++;
            $display("FAIL glitch_fetch got %h want 01 (model %h)", d, e);
        end
    endtask

    task automatic test_mask_capture();
        logic [7:0] seen;
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge CLK_I);
        i_inputs = 8'hA5;
        watch(14);
        seen = 8'h00;
        for (int i = 0; i < 14; i++) seen |= rise_obs[i];
        total++;
        if (seen !== 8'hA4) begin
            bad++;
            $display("FAIL settle_rises got %h want a4", seen);
        end
        fetch(8'h0F, 8'hF0, s, d);
        e = exp_q.pop_front();
        total++;
        if (s !== 3'b010 || d !== 8'h05 || d !== e) begin
            bad++;
            $display("FAIL mask_capture got stb=%b dat=%h want 010 05 (model %h)", s, d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mask;
        logic       st[12];
        logic [7:0] dv[12];
        logic [7:0] ev[12];
        int         pulses;
        mask = 8'($urandom);
        @(negedge CLK_I);
        bus.STB_I = 1'b1;
        bus.DAT_I = mask;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK_I);
            st[i] = bus.STB_O;
            dv[i] = bus.DAT_O;
            ev[i] = m_stable & mask;
            if (i == 8) bus.STB_I = 1'b0;
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            // strobe high on 9 edges: accepts on edges 0,3,6, acks visible one edge later
            total++;
            if (st[i] !== ((i % 3 == 1) && (i < 9))) begin
                bad++;
                $display("FAIL b2b_stb[%0d] got %b want %b", i, st[i], (i % 3 == 1) && (i < 9));
            end
            if (st[i] === 1'b1) begin
                pulses++;
                total++;
                if (dv[i] !== ev[i]) begin
                    bad++;
                    $display("FAIL b2b_dat[%0d] got %h want %h", i, dv[i], ev[i]);
                end
            end
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", pulses);
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        int         n;
        for (int r = 0; r < 12; r++) begin
            @(negedge CLK_I);
            i_inputs = 8'($urandom);
            n = $urandom_range(1, 14);
            watch(n);
            for (int i = 0; i < n; i++) begin
                total++;
                if (rise_obs[i] !== rise_exp[i]) begin
                    bad++;
                    $display("FAIL rand_rise[%0d.%0d] got %h want %h", r, i, rise_obs[i], rise_exp[i]);
                end
            end
            fetch(8'($urandom), 8'($urandom), s, d);
            e = exp_q.pop_front();
            total++;
            if (s !== 3'b010 || d !== e) begin
                bad++;
                $display("FAIL rand_fetch[%0d] got stb=%b dat=%h want 010 %h", r, s, d, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [2:0] s;
        logic [7:0] d;
        logic [7:0] e;
        @(negedge CLK_I);
        i_inputs = 8'hA5;
        watch(14);
        fetch(8'hFF, 8'h00, s, d);
        e = exp_q.pop_front();
        total++;
        if (d !== 8'hA5 || d !== e) begin
            bad++;
            $display("FAIL pre_abort_fetch got %h want a5 (model %h)", d, e);
        end
        @(negedge CLK_I);
        bus.STB_I = 1'b1;
        bus.DAT_I = 8'hFF;
        @(negedge CLK_I);
        bus.STB_I = 1'b0;
        RST_I     = 1'b0;
        #1;
        total++;
        if (bus.STB_O !== 1'b0 || bus.DAT_O !== 8'h00 || o_rise !== 8'h00) begin
            bad++;
            $display("FAIL abort_clear got stb=%b dat=%h rise=%h want 0 00 00",
                     bus.STB_O, bus.DAT_O, o_rise);
        end
        @(negedge CLK_I);
        RST_I = 1'b1;
        watch(10);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (stb_obs[i] !== 1'b0 || rise_obs[i] !== rise_exp[i]) begin
                bad++;
                $display("FAIL abort_after[%0d] got stb=%b rise=%h want 0 %h",
                         i, stb_obs[i], rise_obs[i], rise_exp[i]);
            end
        end
    endtask

    task automatic test_alive();
        int toggles;
        logic prev;
        toggles = 0;
        prev    = o_alive;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_I);
            total++;
            // MSB of a 2^AB wrap counter: flips every 2^(AB-1) edges since reset
            if (o_alive !== 1'((m_edges / (1 << (AB - 1))) % 2)) begin
                bad++;
                $display("FAIL alive[%0d] got %b want %b after %0d edges",
                         i, o_alive, (m_edges / (1 << (AB - 1))) % 2, m_edges);
            end
            if (o_alive !== prev) toggles++;
            prev = o_alive;
        end
        total++;
        if (toggles !== 5) begin
            bad++;
            $display("FAIL alive_toggles got %0d want 5", toggles);
        end
    endtask

    initial begin
        bus.STB_I = 1'b0;
        bus.DAT_I = 8'h00;
        test_reset();
        test_first_fetch();
        test_rise();
        test_glitch();
        test_mask_capture();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_alive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
